// File: rtl/mul_share_pkg.sv
// Shared types and constants for the two-requester shared-multiplier arbiter.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package mul_share_pkg;

    localparam int OP_W_DEF  = 4;
    localparam int CNT_W_DEF = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        RESP = 2'd2
    } state_t;

    // Index of a requester (0 or 1).
    typedef logic req_idx_t;

    // Round-robin pick. A lone valid requester wins outright; on a tie the
    // requester that was not granted last wins. Callers only use the result
    // when at least one valid is high.
    function automatic req_idx_t rr_pick(input logic v0, input logic v1,
                                         input req_idx_t last);
        req_idx_t g;
        if (v0 && v1) begin
            g = ~last;
        end else begin
            g = v0 ? 1'b0 : 1'b1;
        end
        return g;
    endfunction

endpackage

// File: rtl/mul_share_arbiter_if.sv
// Request/response/counter bundle between the arbiter and its environment.
// Latency: n/a (signal bundle only).
// Backpressure: valid/ready on both requests and on the response.
// Ports: req0/req1 valid/ready/a/b, rsp valid/ready/data/id, cnt_clr,
//        done_cnt0/done_cnt1. The slave modport is the arbiter side.
interface mul_share_arbiter_if #(
    parameter int OP_W  = 4,
    parameter int CNT_W = 8
);
    logic              req0_valid;
    logic              req0_ready;
    logic [OP_W-1:0]   req0_a;
    logic [OP_W-1:0]   req0_b;
    logic              req1_valid;
    logic              req1_ready;
    logic [OP_W-1:0]   req1_a;
    logic [OP_W-1:0]   req1_b;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [2*OP_W-1:0] rsp_data;
    logic              rsp_id;
    logic              cnt_clr;
    logic [CNT_W-1:0]  done_cnt0;
    logic [CNT_W-1:0]  done_cnt1;

    modport slave (
        input  req0_valid, req0_a, req0_b,
        input  req1_valid, req1_a, req1_b,
        input  rsp_ready, cnt_clr,
        output req0_ready, req1_ready,
        output rsp_valid, rsp_data, rsp_id,
        output done_cnt0, done_cnt1
    );

    modport master (
        output req0_valid, req0_a, req0_b,
        output req1_valid, req1_a, req1_b,
        output rsp_ready, cnt_clr,
        input  req0_ready, req1_ready,
        input  rsp_valid, rsp_data, rsp_id,
        input  done_cnt0, done_cnt1
    );
endinterface

// File: rtl/mul_share_arbiter_wallace_mul4.sv
// 4x4 unsigned Wallace-tree multiplier (carry-save reduction + final add).
// Latency: combinational, zero cycles.
// Backpressure: none (pure function of its inputs).
// Ports: a_i, b_i 4-bit operands; p_o 8-bit full product.
module wallace_mul4 (
    input  logic [3:0] a_i,
    input  logic [3:0] b_i,
    output logic [7:0] p_o
);
    logic [7:0] pp0, pp1, pp2, pp3;
    logic [7:0] s1, c1, s2, c2;
    logic [6:0] m1, m2;

    // Partial-product rows aligned to their weights.
    assign pp0 = {4'b0, a_i & {4{b_i[0]}}};
    assign pp1 = {3'b0, a_i & {4{b_i[1]}}, 1'b0};
    assign pp2 = {2'b0, a_i & {4{b_i[2]}}, 2'b0};
    assign pp3 = {1'b0, a_i & {4{b_i[3]}}, 3'b0};

    // Layer 1: 3:2 compress rows 0..2. The majority's bit 7 would land at
    // weight 256, which a 4x4 product never reaches, so it is not formed.
    assign s1 = pp0 ^ pp1 ^ pp2;
    assign m1 = (pp0[6:0] & pp1[6:0]) | (pp0[6:0] & pp2[6:0]) | (pp1[6:0] & pp2[6:0]);
    assign c1 = {m1, 1'b0};

    // Layer 2: fold in row 3.
    assign s2 = s1 ^ c1 ^ pp3;
    assign m2 = (s1[6:0] & c1[6:0]) | (s1[6:0] & pp3[6:0]) | (c1[6:0] & pp3[6:0]);
    assign c2 = {m2, 1'b0};

    // Final carry-propagate add.
    assign p_o = s2 + c2;
endmodule

// File: rtl/mul_share_arbiter.sv
// Round-robin arbiter sharing one multiplier between two requesters.
// Latency: accept at cycle N -> rsp_valid at N+2; one transaction per 3 cycles.
// Backpressure: response held stable until rsp_ready; no request accepted meanwhile.
// Ports: clk, rst (async active-high); bus (slave modport) carrying both
//        request channels, the response channel, cnt_clr and done counters.
import mul_share_pkg::*;

module mul_share_arbiter #(
    parameter int OP_W  = OP_W_DEF,   // shared multiplier is 4x4, keep at 4
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic               clk,
    input  logic               rst,
    mul_share_arbiter_if.slave bus
);
    state_t            state_q, state_d;
    logic [OP_W-1:0]   op_a_q, op_a_d;
    logic [OP_W-1:0]   op_b_q, op_b_d;
    req_idx_t          id_q, id_d;
    req_idx_t          last_q, last_d;
    logic [2*OP_W-1:0] rsp_data_q, rsp_data_d;
    logic [CNT_W-1:0]  cnt0_q, cnt0_d;
    logic [CNT_W-1:0]  cnt1_q, cnt1_d;
    logic [2*OP_W-1:0] prod;
    req_idx_t          grant;
    logic              rdy0, rdy1;

    // Only the captured operands feed the multiplier, so operand changes on
    // the request bus after acceptance cannot disturb the in-flight result.
    wallace_mul4 u_mul (
        .a_i (op_a_q),
        .b_i (op_b_q),
        .p_o (prod)
    );

    always_comb begin
        state_d    = state_q;
        op_a_d     = op_a_q;
        op_b_d     = op_b_q;
        id_d       = id_q;
        last_d     = last_q;
        rsp_data_d = rsp_data_q;
        cnt0_d     = cnt0_q;
        cnt1_d     = cnt1_q;
        rdy0       = 1'b0;
        rdy1       = 1'b0;
        grant      = rr_pick(bus.req0_valid, bus.req1_valid, last_q);

        case (state_q)
            IDLE: begin
                // Ready is gated by rst so nothing is signalled as accepted
                // while the registers are held in reset.
                if ((bus.req0_valid || bus.req1_valid) && !rst) begin
                    state_d = CALC;
                    id_d    = grant;
                    op_a_d  = grant ? bus.req1_a : bus.req0_a;
                    op_b_d  = grant ? bus.req1_b : bus.req0_b;
                    rdy0    = ~grant;
                    rdy1    = grant;
                end
            end
            CALC: begin
                rsp_data_d = prod;
                state_d    = RESP;
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    state_d = IDLE;
                    last_d  = id_q;
                    if (id_q) begin
                        cnt1_d = cnt1_q + CNT_W'(1);
                    end else begin
                        cnt0_d = cnt0_q + CNT_W'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Clear overrides a same-cycle increment.
        if (bus.cnt_clr) begin
            cnt0_d = '0;
            cnt1_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            op_a_q     <= '0;
            op_b_q     <= '0;
            id_q       <= 1'b0;
            last_q     <= 1'b1;   // requester 0 wins the first tie
            rsp_data_q <= '0;
            cnt0_q     <= '0;
            cnt1_q     <= '0;
        end else begin
            state_q    <= state_d;
            op_a_q     <= op_a_d;
            op_b_q     <= op_b_d;
            id_q       <= id_d;
            last_q     <= last_d;
            rsp_data_q <= rsp_data_d;
            cnt0_q     <= cnt0_d;
            cnt1_q     <= cnt1_d;
        end
    end

    assign bus.req0_ready = rdy0;
    assign bus.req1_ready = rdy1;
    assign bus.rsp_valid  = (state_q == RESP);
    assign bus.rsp_data   = rsp_data_q;
    assign bus.rsp_id     = id_q;
    assign bus.done_cnt0  = cnt0_q;
    assign bus.done_cnt1  = cnt1_q;
endmodule

// File: tb/tb_mul_share_arbiter.sv
// Self-checking bench for mul_share_arbiter: transaction-level model plus directed literal checks.
// Latency: n/a (testbench).
// Backpressure: drives rsp_ready both held high and randomly toggled.
module tb_mul_share_arbiter;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mul_share_arbiter_if #(.OP_W(4), .CNT_W(8)) bus ();

    mul_share_arbiter #(.OP_W(4), .CNT_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int tests = 0;
    int fails = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- transaction-level model ----------------
    // One transaction at most is outstanding: it is accepted in some cycle,
    // its result is due two cycles later, and it retires on the first cycle
    // from then on that the consumer is ready.
    bit         m_busy = 1'b0;
    int         m_acc_cyc = 0;
    logic [3:0] m_a = '0, m_b = '0;
    bit         m_id = 1'b0;
    bit         m_last = 1'b1;
    logic [7:0] m_cnt0 = '0, m_cnt1 = '0;
    int         cyc = 0;

    logic [7:0] log_data[$];
    bit         log_id[$];

    logic       s_rst, s_v0, s_v1, s_rrdy, s_clr;
    logic [3:0] s_a0, s_b0, s_a1, s_b1;
    bit         ev;

    function automatic bit pick(input bit v0, input bit v1, input bit last);
        if (v0 && !v1) return 1'b0;
        if (v1 && !v0) return 1'b1;
        return (last == 1'b0) ? 1'b1 : 1'b0;
    endfunction

    initial begin
        bit g, done;
        logic [7:0] exp_p;
        forever begin
            @(negedge clk);
            s_rst = rst;   s_v0 = bus.req0_valid; s_v1 = bus.req1_valid;
            s_rrdy = bus.rsp_ready; s_clr = bus.cnt_clr;
            s_a0 = bus.req0_a; s_b0 = bus.req0_b; s_a1 = bus.req1_a; s_b1 = bus.req1_b;
            ev = 1'b0;
            if (s_rst) begin
                chk("rst_rdy0", bus.req0_ready, 1'b0);
                chk("rst_rdy1", bus.req1_ready, 1'b0);
                chk("rst_valid", bus.rsp_valid, 1'b0);
                chk("rst_data", bus.rsp_data, 8'h00);
                chk("rst_id", bus.rsp_id, 1'b0);
                chk("rst_cnt0", bus.done_cnt0, 8'h00);
                chk("rst_cnt1", bus.done_cnt1, 8'h00);
            end else begin
                g = pick(s_v0, s_v1, m_last);
                chk("rdy0", bus.req0_ready, (!m_busy && (s_v0 || s_v1) && g == 1'b0));
                chk("rdy1", bus.req1_ready, (!m_busy && (s_v0 || s_v1) && g == 1'b1));
                ev = m_busy && (cyc >= m_acc_cyc + 2);
                chk("rsp_valid", bus.rsp_valid, ev);
                if (ev) begin
                    exp_p = m_a * m_b;
                    chk("rsp_data", bus.rsp_data, exp_p);
                    chk("rsp_id", bus.rsp_id, m_id);
                end
                chk("cnt0", bus.done_cnt0, m_cnt0);
                chk("cnt1", bus.done_cnt1, m_cnt1);
                if (bus.rsp_valid && s_rrdy) begin
                    log_data.push_back(bus.rsp_data);
                    log_id.push_back(bus.rsp_id);
                end
            end
            @(posedge clk);
            cyc++;
            if (s_rst) begin
                m_busy = 1'b0; m_last = 1'b1; m_cnt0 = '0; m_cnt1 = '0;
            end else begin
                done = ev && s_rrdy;
                if (s_clr) begin
                    m_cnt0 = '0; m_cnt1 = '0;
                end else if (done) begin
                    if (m_id) m_cnt1 = m_cnt1 + 8'd1;
                    else      m_cnt0 = m_cnt0 + 8'd1;
                end
                if (done) begin
                    m_last = m_id; m_busy = 1'b0;
                end else if (!m_busy && (s_v0 || s_v1)) begin
                    g = pick(s_v0, s_v1, m_last);
                    m_busy = 1'b1; m_id = g; m_acc_cyc = cyc - 1;
                    m_a = g ? s_a1 : s_a0;
                    m_b = g ? s_b1 : s_b0;
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
        bus.req0_a = '0; bus.req0_b = '0; bus.req1_a = '0; bus.req1_b = '0;
        bus.rsp_ready = 1'b0; bus.cnt_clr = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        repeat (2) step();
        rst = 1'b0;
    endtask

    initial begin
        logic [7:0] exp8;
        rst = 1'b1;
        idle_inputs();
        repeat (3) step();
        rst = 1'b0;
        step();

        // Single request 15x15 from requester 0.
        log_data.delete(); log_id.delete();
        bus.req0_valid = 1'b1; bus.req0_a = 4'hF; bus.req0_b = 4'hF; bus.rsp_ready = 1'b1;
        #1 chk("single_accept_rdy", bus.req0_ready, 1'b1);
        step();
        bus.req0_valid = 1'b0;
        repeat (4) step();
        chk("single_n", log_data.size(), 1);
        if (log_data.size() >= 1) begin
            chk("single_data", log_data[0], 8'hE1);
            chk("single_id", log_id[0], 1'b0);
        end
        chk("single_cnt0", bus.done_cnt0, 8'd1);

        // Tie fairness: both valid continuously.
        do_reset();
        log_data.delete(); log_id.delete();
        bus.req0_valid = 1'b1; bus.req0_a = 4'd3; bus.req0_b = 4'd5;
        bus.req1_valid = 1'b1; bus.req1_a = 4'd7; bus.req1_b = 4'd9;
        bus.rsp_ready = 1'b1;
        repeat (12) step();
        bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
        repeat (3) step();
        chk("tie_n", log_data.size(), 4);
        for (int i = 0; i < 4 && i < log_data.size(); i++) begin
            exp8 = (i % 2 == 1) ? 8'd63 : 8'd15;
            chk("tie_id", log_id[i], (i % 2 == 1));
            chk("tie_data", log_data[i], exp8);
        end

        // Backpressure with operands changing under a held response.
        do_reset();
        log_data.delete(); log_id.delete();
        bus.req0_valid = 1'b1; bus.req0_a = 4'd6; bus.req0_b = 4'd7; bus.rsp_ready = 1'b0;
        step();
        bus.req1_valid = 1'b1;
        for (int i = 0; i < 7; i++) begin
            bus.req0_a = 4'($urandom); bus.req0_b = 4'($urandom);
            bus.req1_a = 4'($urandom); bus.req1_b = 4'($urandom);
            step();
        end
        bus.req0_valid = 1'b0; bus.req1_valid = 1'b0; bus.rsp_ready = 1'b1;
        step();
        bus.rsp_ready = 1'b0;
        step();
        chk("bp_n", log_data.size(), 1);
        if (log_data.size() >= 1) chk("bp_data", log_data[0], 8'd42);
        chk("bp_cnt0", bus.done_cnt0, 8'd1);
        chk("bp_cnt1", bus.done_cnt1, 8'd0);

        // 256 requester-1 transactions wrap the counter, then clear-vs-increment.
        do_reset();
        log_data.delete(); log_id.delete();
        bus.req1_valid = 1'b1; bus.rsp_ready = 1'b1;
        for (int i = 0; i < 768; i++) begin
            bus.req1_a = 4'($urandom); bus.req1_b = 4'($urandom);
            step();
        end
        bus.req1_valid = 1'b0;
        repeat (3) step();
        chk("wrap_n", log_data.size(), 256);
        chk("wrap_cnt1", bus.done_cnt1, 8'd0);
        bus.req1_valid = 1'b1;
        repeat (6) step();
        bus.req1_valid = 1'b0;
        repeat (2) step();
        chk("pre_clr_cnt1", bus.done_cnt1, 8'd2);
        bus.req1_valid = 1'b1;
        step();
        bus.req1_valid = 1'b0;
        step();
        bus.cnt_clr = 1'b1;
        step();
        bus.cnt_clr = 1'b0;
        chk("clr_wins_cnt1", bus.done_cnt1, 8'd0);
        chk("clr_hs_n", log_data.size(), 259);

        // Reset while the transaction is in CALC.
        do_reset();
        bus.req0_valid = 1'b1; bus.req0_a = 4'd2; bus.req0_b = 4'd2; bus.rsp_ready = 1'b1;
        step();
        bus.req0_valid = 1'b0;
        rst = 1'b1;
        step();
        chk("calc_rst_valid", bus.rsp_valid, 1'b0);
        chk("calc_rst_cnt0", bus.done_cnt0, 8'd0);
        rst = 1'b0;
        log_data.delete(); log_id.delete();
        bus.req0_valid = 1'b1; bus.req0_a = 4'd2; bus.req0_b = 4'd2;
        bus.req1_valid = 1'b1; bus.req1_a = 4'd3; bus.req1_b = 4'd3;
        #1;
        chk("calc_rst_tie_rdy0", bus.req0_ready, 1'b1);
        chk("calc_rst_tie_rdy1", bus.req1_ready, 1'b0);
        step();
        bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
        repeat (3) step();
        chk("calc_rst_n", log_data.size(), 1);
        if (log_data.size() >= 1) chk("calc_rst_data", log_data[0], 8'd4);

        // Exhaustive operand sweep on requester 0.
        do_reset();
        log_data.delete(); log_id.delete();
        bus.rsp_ready = 1'b1;
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                bus.req0_valid = 1'b1; bus.req0_a = 4'(a); bus.req0_b = 4'(b);
                step();
                bus.req0_valid = 1'b0;
                step();
                step();
            end
        end
        step();
        chk("sweep_n", log_data.size(), 256);
        for (int i = 0; i < log_data.size() && i < 256; i++) begin
            exp8 = 8'((i / 16) * (i % 16));
            chk("sweep_data", log_data[i], exp8);
        end

        // Randomised traffic with occasional clears and resets.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            bus.req0_valid = 1'($urandom); bus.req1_valid = 1'($urandom);
            bus.req0_a = 4'($urandom); bus.req0_b = 4'($urandom);
            bus.req1_a = 4'($urandom); bus.req1_b = 4'($urandom);
            bus.rsp_ready = ($urandom_range(0, 3) != 0);
            bus.cnt_clr = ($urandom_range(0, 15) == 0);
            rst = ($urandom_range(0, 299) == 0);
            step();
        end
        rst = 1'b0;
        idle_inputs();
        repeat (4) step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
